// File: rtl/tri_bus_pkg.sv
// -----------------------------------------------------------------------------
// tri_bus_pkg
// Shared definitions for the half-duplex tri-state bus transceiver:
//   - tri_state_e   : FSM state encoding (IDLE=0 .. SAMPLE=4)
//   - DEFAULT_*     : default bus width, drive length and turnaround length
//   - max_int       : helper used to size the shared drive/turnaround counter
// -----------------------------------------------------------------------------
package tri_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRIVE    = 3'd1,
        RELEASE  = 3'd2,
        RX_WAIT  = 3'd3,
        SAMPLE   = 3'd4
    } tri_state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_HOLD  = 2;
    localparam int DEFAULT_TURN  = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tri_buffer.sv
// -----------------------------------------------------------------------------
// tri_buffer
// Combinational tri-state driver: y follows d while enable is high, otherwise
// every bit of y is released to high impedance.
// Ports:
//   d       input  [WIDTH-1:0]  data to place on the net
//   enable  input               drive enable
//   y       output [WIDTH-1:0]  tri-state net
// -----------------------------------------------------------------------------
module tri_buffer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    output wire  [WIDTH-1:0] y
);

    // Release the whole word at once so partial drives can never occur.
    assign y = enable ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/tri_bus_transceiver.sv
// -----------------------------------------------------------------------------
// tri_bus_transceiver
// Half-duplex endpoint on a shared tri-state bus. A transmit word is driven
// for HOLD cycles and then the bus is released for TURN cycles. A receive
// request waits TURN cycles with the bus released and then captures one word.
// Ports:
//   clk       input               clock, all state changes on rising edge
//   rst_n     input               asynchronous active-low reset
//   bus       inout  [WIDTH-1:0]  shared tri-state bus
//   tx_valid  input               local word available to send
//   tx_data   input  [WIDTH-1:0]  word to send, sampled on accept
//   tx_ready  output              high only in IDLE
//   rx_req    input               level request to capture one word
//   rx_valid  output              one-cycle pulse alongside a fresh rx_data
//   rx_data   output [WIDTH-1:0]  last captured bus word
//   oe        output              bus drive enable, decoded from state register
//   busy      output              high in every state except IDLE
// -----------------------------------------------------------------------------
module tri_bus_transceiver
    import tri_bus_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int HOLD  = DEFAULT_HOLD,
    parameter int TURN  = DEFAULT_TURN
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             rx_req,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             oe,
    output logic             busy
);

    localparam int CNT_W = $clog2(max_int(HOLD, TURN)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN - 1);

    tri_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_reg_q, tx_reg_d;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;

    // Next-state logic. The counter is cleared on every state entry and only
    // counts up to the last cycle of the current phase, so it never wraps.
    // Transmit has priority over receive when both are requested in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tx_reg_d = tx_reg_q;
        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    tx_reg_d = tx_data;
                    state_d  = DRIVE;
                    cnt_d    = '0;
                end else if (rx_req) begin
                    state_d = RX_WAIT;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and data registers. The capture happens on the edge that
    // leaves SAMPLE, so rx_valid is high for exactly the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_reg_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_reg_q   <= tx_reg_d;
            rx_valid_q <= (state_q == SAMPLE);
            if (state_q == SAMPLE) begin
                rx_data_q <= bus;
            end
        end
    end

    // Outputs decode the state register only, so oe cannot glitch and drops
    // as soon as the asynchronous reset clears the state.
    assign oe       = (state_q == DRIVE);
    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

    tri_buffer #(
        .WIDTH (WIDTH)
    ) u_tri_buffer (
        .d      (tx_reg_q),
        .enable (oe),
        .y      (bus)
    );

endmodule

// File: tb/tb_tri_bus_transceiver.sv
// -----------------------------------------------------------------------------
// tb_tri_bus_transceiver
// Self-checking bench for tri_bus_transceiver. Expected behaviour is derived
// from transaction-level timing: a transmit occupies HOLD driven cycles then
// TURN released cycles; a receive occupies TURN wait cycles, one sample cycle,
// and then shows rx_valid for one cycle.
// -----------------------------------------------------------------------------
module tb_tri_bus_transceiver;

    localparam int W = 8;
    localparam int H = 2;
    localparam int T = 1;

    logic         clk;
    logic         rst_n;
    wire  [W-1:0] bus;
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_ready;
    logic         rx_req;
    logic         rx_valid;
    logic [W-1:0] rx_data;
    logic         oe;
    logic         busy;

    logic         tbDriveEn;
    logic [W-1:0] tbDriveVal;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    logic [W-1:0] lastRx;

    // Remote end of the bus, only enabled while the DUT is expected to listen.
    assign bus = tbDriveEn ? tbDriveVal : {W{1'bz}};

    tri_bus_transceiver #(
        .WIDTH (W),
        .HOLD  (H),
        .TURN  (T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_req   (rx_req),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .oe       (oe),
        .busy     (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Advance to the next falling edge, where outputs are sampled and inputs
    // are changed.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Checks one cycle of the idle endpoint.
    task automatic check_idle(input string name);
        tests++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || oe !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s idle: tx_ready=%b busy=%b oe=%b required 1 0 0",
                     name, tx_ready, busy, oe);
        end
    endtask

    // Runs one transmit of d starting from an IDLE falling edge. rx_req is
    // left at holdRx throughout; tx_data is scrambled after the accept.
    task automatic do_tx(input logic [W-1:0] d, input logic holdRx, input string name);
        tx_valid = 1'b1;
        tx_data  = d;
        rx_req   = holdRx;
        applyStimulus(1);
        tx_valid = 1'b0;
        tx_data  = W'($urandom);
        for (int i = 0; i < H; i++) begin
            tests++;
            if (oe !== 1'b1 || bus !== d || busy !== 1'b1 || tx_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL %s drive%0d: oe=%b bus=%h busy=%b ready=%b required 1 %h 1 0",
                         name, i, oe, bus, busy, tx_ready, d);
            end
            applyStimulus(1);
        end
        for (int i = 0; i < T; i++) begin
            tests++;
            if (oe !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL %s release%0d: oe=%b busy=%b ready=%b required 0 1 0",
                         name, i, oe, busy, tx_ready);
            end
            applyStimulus(1);
        end
        check_idle(name);
    endtask

    // Runs one capture of v starting from an IDLE falling edge. When the
    // request is already pending the caller has left rx_req high.
    task automatic do_rx(input logic [W-1:0] v, input logic dropReq, input string name);
        rx_req = 1'b1;
        applyStimulus(1);
        tbDriveEn  = 1'b1;
        tbDriveVal = v;
        if (dropReq) rx_req = 1'b0;
        for (int i = 0; i < T + 1; i++) begin
            tests++;
            if (oe !== 1'b0 || busy !== 1'b1 || rx_valid !== 1'b0 || tx_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL %s listen%0d: oe=%b busy=%b rx_valid=%b ready=%b required 0 1 0 0",
                         name, i, oe, busy, rx_valid, tx_ready);
            end
            rx_req = 1'b0;
            applyStimulus(1);
        end
        tbDriveEn = 1'b0;
        lastRx    = v;
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== v || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s capture: rx_valid=%b rx_data=%h busy=%b required 1 %h 0",
                     name, rx_valid, rx_data, busy, v);
        end
        applyStimulus(1);
        tests++;
        if (rx_valid !== 1'b0 || rx_data !== v) begin
            fails++;
            $display("[TB] FAIL %s after: rx_valid=%b rx_data=%h required 0 %h",
                     name, rx_valid, rx_data, v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(2);
        tests++;
        if (oe !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset: oe=%b ready=%b rx_valid=%b rx_data=%h busy=%b required 0 1 0 00 0",
                     oe, tx_ready, rx_valid, rx_data, busy);
        end
        rst_n = 1'b1;
        applyStimulus(1);
        check_idle("reset_release");
    endtask

    task automatic test_single_tx();
        do_tx(8'hA5, 1'b0, "single_tx");
    endtask

    task automatic test_receive();
        do_rx(8'h3C, 1'b0, "receive");
        check_idle("receive_end");
    endtask

    // Transmit and receive requested together: transmit first, then the
    // still-pending request is serviced straight out of the next IDLE cycle.
    task automatic test_simultaneous();
        do_tx(8'h5A, 1'b1, "simul_tx");
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL simul_gap: rx_valid=%b required 0", rx_valid);
        end
        do_rx(8'hC3, 1'b0, "simul_rx");
    endtask

    task automatic test_reset_mid_drive();
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        applyStimulus(1);
        tx_valid = 1'b0;
        @(posedge clk);
        #2;
        tests++;
        if (oe !== 1'b1 || bus !== 8'hFF) begin
            fails++;
            $display("[TB] FAIL middrive_pre: oe=%b bus=%h required 1 ff", oe, bus);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (oe !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL middrive_async: oe=%b ready=%b busy=%b required 0 1 0",
                     oe, tx_ready, busy);
        end
        applyStimulus(1);
        rst_n = 1'b1;
        applyStimulus(1);
        check_idle("middrive_after");
        lastRx = '0;
    endtask

    // tx_valid held high across two words: accept points must be H+T+1
    // cycles apart and the second word must not leak into the first drive.
    task automatic test_back_to_back();
        int acc0;
        acc0 = cycle;
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        applyStimulus(1);
        tx_data = 8'h02;
        for (int i = 0; i < H; i++) begin
            tests++;
            if (oe !== 1'b1 || bus !== 8'h01) begin
                fails++;
                $display("[TB] FAIL b2b_first%0d: oe=%b bus=%h required 1 01", i, oe, bus);
            end
            applyStimulus(1);
        end
        for (int i = 0; i < T; i++) begin
            tests++;
            if (oe !== 1'b0 || tx_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL b2b_gap%0d: oe=%b ready=%b required 0 0", i, oe, tx_ready);
            end
            applyStimulus(1);
        end
        tests++;
        if (tx_ready !== 1'b1 || (cycle - acc0) != H + T + 1) begin
            fails++;
            $display("[TB] FAIL b2b_spacing: ready=%b spacing=%0d required 1 %0d",
                     tx_ready, cycle - acc0, H + T + 1);
        end
        applyStimulus(1);
        tx_valid = 1'b0;
        for (int i = 0; i < H; i++) begin
            tests++;
            if (oe !== 1'b1 || bus !== 8'h02) begin
                fails++;
                $display("[TB] FAIL b2b_second%0d: oe=%b bus=%h required 1 02", i, oe, bus);
            end
            applyStimulus(1);
        end
        applyStimulus(T);
        check_idle("b2b_end");
    endtask

    // Random mix of transmits, receives and combined requests with idle gaps.
    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int kind;
            logic [W-1:0] a, b;
            kind = int'($urandom_range(0, 2));
            a    = W'($urandom);
            b    = W'($urandom);
            case (kind)
                0: do_tx(a, 1'b0, "rand_tx");
                1: begin
                    do_rx(b, ($urandom_range(0, 1) == 1), "rand_rx");
                    check_idle("rand_rx_end");
                end
                default: begin
                    do_tx(a, 1'b1, "rand_both_tx");
                    do_rx(b, 1'b0, "rand_both_rx");
                end
            endcase
            applyStimulus(int'($urandom_range(0, 2)));
            tests++;
            if (rx_data !== lastRx || oe !== 1'b0) begin
                fails++;
                $display("[TB] FAIL rand_hold: rx_data=%h oe=%b required %h 0", rx_data, oe, lastRx);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        rx_req     = 1'b0;
        tbDriveEn  = 1'b0;
        tbDriveVal = '0;
        lastRx     = '0;
        applyStimulus(1);
        test_reset();
        test_single_tx();
        test_receive();
        test_simultaneous();
        test_reset_mid_drive();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
